execute_stage: RTL and testbench

- EX stage of the 5-stage MIPS pipeline; consumes the registered outputs of the ID/EX pipeline register and feeds the EX/MEM register.
- Combinational ALU: arithmetic, logic, shifts, compares, load/store address and branch resolution.
- Iterative multiply/divide unit owns the HI/LO registers and stalls the front end while busy.

---
 rtl/mips_pkg.sv | 74 +++++++
 rtl/execute_stage_if.sv | 40 ++++
 rtl/execute_stage_muldiv_unit.sv | 121 ++++++++++++
 rtl/execute_stage.sv | 126 ++++++++++++
 tb/tb_execute_stage.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcode/funct constants, mul/div FSM states, ALU operation set.
// Pure declarations; no timing or flow-control content.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_MEM_LO = 6'h20;
    localparam logic [5:0] OP_MEM_HI = 6'h2E;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV,
        MD_DONE
    } md_state_t;

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_BR,
        ALU_ADDR,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_PASS_B,
        ALU_MFHI
    } alu_op_t;

    function automatic logic is_muldiv_funct(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX operand bundle into the EX stage and the EX/MEM-facing results.
// No handshake: the ID/EX side holds its values while o_stall is high.
interface execute_stage_if #(
    parameter int NB        = 32,
    parameter int NB_OPCODE = 6,
    parameter int NB_FCODE  = 6,
    parameter int NB_SHAMT  = 5
);
    logic [NB_OPCODE-1:0] i_instruction_op_code;
    logic [NB_FCODE-1:0]  i_instruction_funct_code;
    logic [NB_SHAMT-1:0]  i_shamt;
    logic                 i_alu_src;
    logic [NB-1:0]        i_data_a;
    logic [NB-1:0]        i_data_b;
    logic [NB-1:0]        i_extension_result;
    logic [NB-1:0]        i_pc4;
    logic                 i_branch;
    logic [NB-1:0]        o_alu_result;
    logic                 o_zero;
    logic [NB-1:0]        o_branch_target;
    logic                 o_branch_taken;
    logic [NB-1:0]        o_store_data;
    logic                 o_stall;
    logic [NB-1:0]        o_hi;
    logic [NB-1:0]        o_lo;

    modport master (
        output i_instruction_op_code, i_instruction_funct_code, i_shamt, i_alu_src,
               i_data_a, i_data_b, i_extension_result, i_pc4, i_branch,
        input  o_alu_result, o_zero, o_branch_target, o_branch_taken, o_store_data,
               o_stall, o_hi, o_lo
    );

    modport slave (
        input  i_instruction_op_code, i_instruction_funct_code, i_shamt, i_alu_src,
               i_data_a, i_data_b, i_extension_result, i_pc4, i_branch,
        output o_alu_result, o_zero, o_branch_target, o_branch_taken, o_store_data,
               o_stall, o_hi, o_lo
    );
endinterface

// File: rtl/execute_stage_muldiv_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider owning HI/LO.
// Result lands 33 enabled clocks after issue; stall holds the front end until then.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int NB        = 32,
    parameter int NB_OPCODE = 6,
    parameter int NB_FCODE  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step,
    input  logic [NB_OPCODE-1:0] op_code,
    input  logic [NB_FCODE-1:0]  funct_code,
    input  logic [NB-1:0]        data_a,
    input  logic [NB-1:0]        data_b,
    output logic [NB-1:0]        hi,
    output logic [NB-1:0]        lo,
    output logic                 stall
);
    localparam int NB_CNT = $clog2(NB);

    md_state_t         state, state_nxt;
    logic [NB_CNT-1:0] count;
    logic [NB-1:0]     opnd_b;
    logic [2*NB-1:0]   acc, acc_step, prod;
    logic              neg_q, neg_r;
    logic              is_rtype, start, is_signed, is_div, mthi, mtlo, last;
    logic [NB-1:0]     mag_a, mag_b;
    logic [NB:0]       mul_sum, rem_sh;
    logic [NB-1:0]     rem_diff, quot, rem, hi_fin, lo_fin;

    assign is_rtype  = (op_code == OP_RTYPE);
    assign start     = is_rtype && is_muldiv_funct(funct_code);
    assign is_signed = (funct_code == FN_MULT) || (funct_code == FN_DIV);
    assign is_div    = (funct_code == FN_DIV)  || (funct_code == FN_DIVU);
    assign mthi      = is_rtype && (funct_code == FN_MTHI);
    assign mtlo      = is_rtype && (funct_code == FN_MTLO);
    assign last      = (count == NB_CNT'(NB - 1));
    assign mag_a     = (is_signed && data_a[NB-1]) ? -data_a : data_a;
    assign mag_b     = (is_signed && data_b[NB-1]) ? -data_b : data_b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc[2*NB-1:NB]} + (acc[0] ? {1'b0, opnd_b} : '0);
        rem_sh   = {acc[2*NB-1:NB], acc[NB-1]};
        rem_diff = rem_sh[NB-1:0] - opnd_b;
        if (state == MD_DIV) begin
            if (rem_sh >= {1'b0, opnd_b}) acc_step = {rem_diff, acc[NB-2:0], 1'b1};
            else                          acc_step = {rem_sh[NB-1:0], acc[NB-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[NB-1:1]};
        end
    end

    assign prod   = neg_q ? -acc_step : acc_step;
    assign quot   = acc_step[NB-1:0];
    assign rem    = acc_step[2*NB-1:NB];
    assign hi_fin = (state == MD_DIV) ? (neg_r ? -rem : rem)   : prod[2*NB-1:NB];
    assign lo_fin = (state == MD_DIV) ? (neg_q ? -quot : quot) : prod[NB-1:0];

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            MD_IDLE: begin
                stall = start;
                if (start) state_nxt = is_div ? MD_DIV : MD_MUL;
            end
            MD_MUL, MD_DIV: begin
                stall = 1'b1;
                if (last) state_nxt = MD_DONE;
            end
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)     state <= MD_IDLE;
        else if (step) state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            acc    <= '0;
            opnd_b <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (step) begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        acc    <= {{NB{1'b0}}, mag_a};
                        opnd_b <= mag_b;
                        count  <= '0;
                        // divide-by-zero keeps the all-ones quotient unsigned
                        neg_q  <= is_signed && (data_a[NB-1] ^ data_b[NB-1]) && (data_b != '0);
                        neg_r  <= is_signed && data_a[NB-1];
                    end else begin
                        if (mthi) hi <= data_a;
                        if (mtlo) lo <= data_a;
                    end
                end
                MD_MUL, MD_DIV: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                    if (last) begin
                        hi <= hi_fin;
                        lo <= lo_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: combinational ALU, immediate formatting and branch resolution.
// ALU results are same-cycle; o_stall from the mul/div unit holds the front end.
module execute_stage
    import mips_pkg::*;
#(
    parameter int NB        = 32,
    parameter int NB_OPCODE = 6,
    parameter int NB_FCODE  = 6,
    parameter int NB_SHAMT  = 5
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_step,
    execute_stage_if.slave ex
);
    alu_op_t             alu_op;
    logic                var_shift;
    logic                use_lo;
    logic [NB-1:0]       imm, op_b, result;
    logic [NB_SHAMT-1:0] shamt;
    logic [NB-1:0]       hi, lo;
    logic                stall;

    muldiv_unit #(
        .NB        (NB),
        .NB_OPCODE (NB_OPCODE),
        .NB_FCODE  (NB_FCODE)
    ) u_muldiv (
        .clk        (i_clk),
        .reset      (i_reset),
        .step       (i_step),
        .op_code    (ex.i_instruction_op_code),
        .funct_code (ex.i_instruction_funct_code),
        .data_a     (ex.i_data_a),
        .data_b     (ex.i_data_b),
        .hi         (hi),
        .lo         (lo),
        .stall      (stall)
    );

    always_comb begin
        alu_op    = ALU_NONE;
        var_shift = 1'b0;
        use_lo    = 1'b0;
        case (ex.i_instruction_op_code)
            OP_RTYPE: begin
                case (ex.i_instruction_funct_code)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SRA:  alu_op = ALU_SRA;
                    FN_SLLV: begin alu_op = ALU_SLL; var_shift = 1'b1; end
                    FN_SRLV: begin alu_op = ALU_SRL; var_shift = 1'b1; end
                    FN_SRAV: begin alu_op = ALU_SRA; var_shift = 1'b1; end
                    FN_MFHI: alu_op = ALU_MFHI;
                    FN_MFLO: begin alu_op = ALU_MFHI; use_lo = 1'b1; end
                    default: alu_op = ALU_NONE;
                endcase
            end
            OP_BEQ, OP_BNE:    alu_op = ALU_BR;
            OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
            OP_SLTI:           alu_op = ALU_SLT;
            OP_SLTIU:          alu_op = ALU_SLTU;
            OP_ANDI:           alu_op = ALU_AND;
            OP_ORI:            alu_op = ALU_OR;
            OP_XORI:           alu_op = ALU_XOR;
            OP_LUI:            alu_op = ALU_PASS_B;
            default: begin
                if (ex.i_instruction_op_code >= OP_MEM_LO && ex.i_instruction_op_code <= OP_MEM_HI)
                    alu_op = ALU_ADDR;
            end
        endcase
    end

    always_comb begin
        case (ex.i_instruction_op_code)
            OP_ANDI, OP_ORI, OP_XORI: imm = {{(NB-16){1'b0}}, ex.i_extension_result[15:0]};
            OP_LUI:                   imm = {ex.i_extension_result[15:0], {(NB-16){1'b0}}};
            default:                  imm = ex.i_extension_result;
        endcase
    end

    assign op_b  = ex.i_alu_src ? imm : ex.i_data_b;
    assign shamt = var_shift ? ex.i_data_a[NB_SHAMT-1:0] : ex.i_shamt;

    // shifts always act on rt; branches always compare rs against rt
    always_comb begin
        case (alu_op)
            ALU_ADD:    result = ex.i_data_a + op_b;
            ALU_SUB:    result = ex.i_data_a - op_b;
            ALU_BR:     result = ex.i_data_a - ex.i_data_b;
            ALU_ADDR:   result = ex.i_data_a + ex.i_extension_result;
            ALU_AND:    result = ex.i_data_a & op_b;
            ALU_OR:     result = ex.i_data_a | op_b;
            ALU_XOR:    result = ex.i_data_a ^ op_b;
            ALU_NOR:    result = ~(ex.i_data_a | op_b);
            ALU_SLT:    result = {{(NB-1){1'b0}}, $signed(ex.i_data_a) < $signed(op_b)};
            ALU_SLTU:   result = {{(NB-1){1'b0}}, ex.i_data_a < op_b};
            ALU_SLL:    result = ex.i_data_b << shamt;
            ALU_SRL:    result = ex.i_data_b >> shamt;
            ALU_SRA:    result = $signed(ex.i_data_b) >>> shamt;
            ALU_PASS_B: result = op_b;
            ALU_MFHI:   result = use_lo ? lo : hi;
            default:    result = '0;
        endcase
    end

    assign ex.o_alu_result    = result;
    assign ex.o_zero          = (result == '0);
    assign ex.o_branch_target = ex.i_pc4 + (ex.i_extension_result << 2);
    assign ex.o_branch_taken  = ex.i_branch &&
                                (((ex.i_instruction_op_code == OP_BEQ) && (ex.i_data_a == ex.i_data_b)) ||
                                 ((ex.i_instruction_op_code == OP_BNE) && (ex.i_data_a != ex.i_data_b)));
    assign ex.o_store_data    = ex.i_data_b;
    assign ex.o_stall         = stall;
    assign ex.o_hi            = hi;
    assign ex.o_lo            = lo;

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage: stimulus pushes expectations, a negedge monitor checks them.
module tb_execute_stage;
    import mips_pkg::*;

    typedef enum int {S_RES, S_ZERO, S_TGT, S_TAKEN, S_STORE, S_STALL, S_HI, S_LO} sel_t;
    typedef struct {
        string       name;
        sel_t        sel;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic step;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] mon_act;
    int checks = 0;
    int errors = 0;

    execute_stage_if #(.NB(32), .NB_OPCODE(6), .NB_FCODE(6), .NB_SHAMT(5)) bus ();

    execute_stage #(.NB(32), .NB_OPCODE(6), .NB_FCODE(6), .NB_SHAMT(5)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_step  (step),
        .ex      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input sel_t s);
        case (s)
            S_RES:   return bus.o_alu_result;
            S_ZERO:  return {31'b0, bus.o_zero};
            S_TGT:   return bus.o_branch_target;
            S_TAKEN: return {31'b0, bus.o_branch_taken};
            S_STORE: return bus.o_store_data;
            S_STALL: return {31'b0, bus.o_stall};
            S_HI:    return bus.o_hi;
            S_LO:    return bus.o_lo;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = actual(mon_e.sel);
            checks++;
            if (mon_act !== mon_e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input string name, input sel_t sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ext, input logic src,
                         input logic br, input logic [4:0] sh, input logic [31:0] pc4);
        bus.i_instruction_op_code    = op;
        bus.i_instruction_funct_code = fn;
        bus.i_data_a                 = a;
        bus.i_data_b                 = b;
        bus.i_extension_result       = ext;
        bus.i_alu_src                = src;
        bus.i_branch                 = br;
        bus.i_shamt                  = sh;
        bus.i_pc4                    = pc4;
    endtask

    task automatic nop();
        drive(OP_RTYPE, FN_ADDU, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic run_muldiv(input string name, input logic [5:0] fn, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        drive(OP_RTYPE, fn, a, b, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 33; k++) begin
            exp_push({name, "_stall_busy"}, S_STALL, 32'd1);
            tick();
        end
        exp_push({name, "_stall_done"}, S_STALL, 32'd0);
        exp_push({name, "_hi"}, S_HI, exp_hi);
        exp_push({name, "_lo"}, S_LO, exp_lo);
        tick();
        nop();
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        step  = 1'b1;
        nop();
        tick();
        tick();
        reset = 1'b0;
        exp_push("rst_stall", S_STALL, 32'd0);
        exp_push("rst_hi", S_HI, 32'h0);
        exp_push("rst_lo", S_LO, 32'h0);
        exp_push("rst_zero", S_ZERO, 32'd1);
        tick();

        // R-type arithmetic and logic
        drive(OP_RTYPE, FN_ADDU, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_push("addu_res", S_RES, 32'h8000_0000);
        exp_push("addu_zero", S_ZERO, 32'd0);
        exp_push("addu_store", S_STORE, 32'h1);
        #1;
        checks++;
        if (bus.o_alu_result !== 32'h8000_0000) begin
            errors++;
            $display("FAIL addu_direct: got %h expected %h", bus.o_alu_result, 32'h8000_0000);
        end
        tick();
        drive(OP_RTYPE, FN_SLT, 32'hFFFF_FFFB, 32'h3, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_push("slt_res", S_RES, 32'h1);
        #1;
        checks++;
        if (bus.o_alu_result !== 32'h1) begin
            errors++;
            $display("FAIL slt_direct: got %h expected %h", bus.o_alu_result, 32'h1);
        end
        tick();
        drive(OP_RTYPE, FN_SLTU, 32'hFFFF_FFFB, 32'h3, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_push("sltu_res", S_RES, 32'h0);
        tick();
        drive(OP_RTYPE, FN_SUBU, 32'h5, 32'h5, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_push("subu_res", S_RES, 32'h0);
        exp_push("subu_zero", S_ZERO, 32'd1);
        tick();
        drive(OP_RTYPE, FN_NOR, 32'h0, 32'h0F0F_0F0F, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_push("nor_res", S_RES, 32'hF0F0_F0F0);
        tick();
        drive(OP_RTYPE, FN_SRA, 32'h0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 5'd4, 32'h0);
        exp_push("sra_res", S_RES, 32'hF800_0000);
        tick();
        drive(OP_RTYPE, FN_SRL, 32'h0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 5'd4, 32'h0);
        exp_push("srl_res", S_RES, 32'h0800_0000);
        tick();
        drive(OP_RTYPE, FN_SLLV, 32'h24, 32'h1, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_push("sllv_res", S_RES, 32'h10);
        tick();
        drive(OP_RTYPE, 6'h01, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_push("bad_funct_res", S_RES, 32'h0);
        tick();

        // branches
        drive(OP_BEQ, 6'h0, 32'h9, 32'h9, 32'hFFFF_FFFE, 1'b0, 1'b1, 5'd0, 32'h100);
        exp_push("beq_taken", S_TAKEN, 32'd1);
        exp_push("beq_target", S_TGT, 32'h0000_00F8);
        exp_push("beq_zero", S_ZERO, 32'd1);
        #1;
        checks++;
        if (bus.o_branch_target !== 32'h0000_00F8) begin
            errors++;
            $display("FAIL beq_target_direct: got %h expected %h", bus.o_branch_target, 32'h0000_00F8);
        end
        tick();
        drive(OP_BEQ, 6'h0, 32'h9, 32'h9, 32'hFFFF_FFFE, 1'b0, 1'b0, 5'd0, 32'h100);
        exp_push("beq_nobranch", S_TAKEN, 32'd0);
        tick();
        drive(OP_BNE, 6'h0, 32'h9, 32'h9, 32'h4, 1'b0, 1'b1, 5'd0, 32'h200);
        exp_push("bne_eq_taken", S_TAKEN, 32'd0);
        exp_push("bne_target", S_TGT, 32'h210);
        tick();
        drive(OP_BNE, 6'h0, 32'h9, 32'h8, 32'h4, 1'b0, 1'b1, 5'd0, 32'h200);
        exp_push("bne_ne_taken", S_TAKEN, 32'd1);
        exp_push("bne_res", S_RES, 32'h1);
        tick();

        // immediates, memory addressing, unknown opcode
        drive(OP_LUI, 6'h0, 32'h0, 32'h0, 32'h0000_1234, 1'b1, 1'b0, 5'd0, 32'h0);
        exp_push("lui_res", S_RES, 32'h1234_0000);
        tick();
        drive(OP_ORI, 6'h0, 32'hF000_0000, 32'h0, 32'hFFFF_8001, 1'b1, 1'b0, 5'd0, 32'h0);
        exp_push("ori_res", S_RES, 32'hF000_8001);
        tick();
        drive(OP_ADDI, 6'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0, 32'h0);
        exp_push("addi_res", S_RES, 32'h0);
        exp_push("addi_zero", S_ZERO, 32'd1);
        tick();
        drive(OP_SLTI, 6'h0, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 5'd0, 32'h0);
        exp_push("slti_res", S_RES, 32'h1);
        tick();
        drive(6'h23, 6'h0, 32'h1000, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 5'd0, 32'h0);
        exp_push("lw_addr", S_RES, 32'h0000_0FFC);
        tick();
        drive(6'h2B, 6'h0, 32'h2000, 32'hDEAD_BEEF, 32'h8, 1'b1, 1'b0, 5'd0, 32'h0);
        exp_push("sw_addr", S_RES, 32'h2008);
        exp_push("sw_store", S_STORE, 32'hDEAD_BEEF);
        tick();
        drive(6'h3F, 6'h0, 32'h1, 32'h1, 32'h0, 1'b0, 1'b1, 5'd0, 32'h0);
        exp_push("bad_op_res", S_RES, 32'h0);
        exp_push("bad_op_taken", S_TAKEN, 32'd0);
        tick();

        // HI/LO moves
        drive(OP_RTYPE, FN_MTHI, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_push("mthi_stall", S_STALL, 32'd0);
        tick();
        exp_push("mthi_hi", S_HI, 32'h1234);
        drive(OP_RTYPE, FN_MTLO, 32'h5678, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        exp_push("mtlo_lo", S_LO, 32'h5678);
        nop();
        tick();

        // multiply / divide
        run_muldiv("mult", FN_MULT, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        drive(OP_RTYPE, FN_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_push("mflo_res", S_RES, 32'hFFFF_FFEB);
        #1;
        checks++;
        if (bus.o_alu_result !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mflo_direct: got %h expected %h", bus.o_alu_result, 32'hFFFF_FFEB);
        end
        tick();
        drive(OP_RTYPE, FN_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_push("mfhi_res", S_RES, 32'hFFFF_FFFF);
        tick();
        run_muldiv("div", FN_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_muldiv("divu0", FN_DIVU, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF);
        run_muldiv("div_ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // MULTU with a 10-cycle step freeze after the fifth enabled edge
        drive(OP_RTYPE, FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            exp_push("frz_stall_pre", S_STALL, 32'd1);
            tick();
        end
        step = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_push("frz_stall_hold", S_STALL, 32'd1);
            exp_push("frz_hi_hold", S_HI, 32'h0);
            exp_push("frz_lo_hold", S_LO, 32'h8000_0000);
            tick();
        end
        step = 1'b1;
        for (int k = 5; k < 33; k++) begin
            exp_push("frz_stall_post", S_STALL, 32'd1);
            tick();
        end
        exp_push("frz_stall_done", S_STALL, 32'd0);
        exp_push("frz_hi", S_HI, 32'hFFFF_FFFE);
        exp_push("frz_lo", S_LO, 32'h0000_0001);
        tick();
        nop();

        // reset in the middle of a MULTU discards everything
        drive(OP_RTYPE, FN_MULTU, 32'h3, 32'h5, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 16; k++) begin
            exp_push("mrst_stall_busy", S_STALL, 32'd1);
            tick();
        end
        reset = 1'b1;
        nop();
        tick();
        reset = 1'b0;
        exp_push("mrst_stall", S_STALL, 32'd0);
        exp_push("mrst_hi", S_HI, 32'h0);
        exp_push("mrst_lo", S_LO, 32'h0);
        tick();
        exp_push("mrst_stall_idle", S_STALL, 32'd0);
        tick();
        run_muldiv("multu_after_rst", FN_MULTU, 32'h3, 32'h5, 32'h0, 32'hF);

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
